// File: rtl/wb_pkg.sv
// ----------------------------------------------------------------------------
// wb_pkg
//
// Shared definitions for the register-file write-back arbiter.
//
// Contents:
//   WB_WORDSIZE  default result / register-file data width
//   WB_DEPTH     default number of buffered mul/div results
//   WB_STARVE    default number of consecutive lost arbitrations the
//                buffered mul/div head tolerates before a stall is requested
//   wb_req_t     one pending register-file write (destination + data)
//   wb_is_real_dest()  true when a destination is an architectural register
//                      that can actually be written (x0 is hard-wired zero)
// ----------------------------------------------------------------------------
package wb_pkg;

   localparam int WB_WORDSIZE = 32;
   localparam int WB_DEPTH    = 4;
   localparam int WB_STARVE   = 8;

   // One pending write to the register file.
   typedef struct packed {
      logic [4:0]             rdn;
      logic [WB_WORDSIZE-1:0] rdd;
   } wb_req_t;

   // Writes to x0 have no architectural effect, so anything targeting it is
   // dropped rather than spending a write-port slot on it.
   function automatic logic wb_is_real_dest(input logic [4:0] rdn);
      return (rdn != 5'd0);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
//
// Small synchronous FIFO that buffers mul/div results until the write port
// is free. The entry type is a parameter so the arbiter can hand in a
// request struct sized to its own data width.
//
// Parameters:
//   Depth    number of entries (power of two, >= 2)
//   entry_t  stored element type
//
// Ports:
//   clk    in   clock, all state changes on posedge
//   rstn   in   asynchronous active-low reset; empties the FIFO
//   push   in   write push_data this cycle (ignored when full)
//   data   in   entry to store
//   pop    in   discard the head this cycle (ignored when empty)
//   full   out  no free entry (from registered count only)
//   empty  out  no stored entry (from registered count only)
//   head   out  oldest stored entry, valid whenever empty is low
// ----------------------------------------------------------------------------
module wb_fifo
   import wb_pkg::*;
#(
   parameter int  Depth   = WB_DEPTH,
   parameter type entry_t = wb_req_t
) (
   input  logic   clk,
   input  logic   rstn,
   input  logic   push,
   input  entry_t data,
   input  logic   pop,
   output logic   full,
   output logic   empty,
   output entry_t head
);

   localparam int PtrW = $clog2(Depth);

   entry_t            mem [Depth];
   logic [PtrW-1:0]   rd_ptr;
   logic [PtrW-1:0]   wr_ptr;
   logic [PtrW:0]     count;
   logic              do_push;
   logic              do_pop;

   // Status comes purely from the registered count, so a same-cycle pop can
   // never open a slot for a push in that cycle.
   assign full  = (count == (PtrW+1)'(Depth));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   assign do_push = push && !full;
   assign do_pop  = pop  && !empty;

   // Storage has no reset: an entry is only ever read after it was written,
   // and emptiness is tracked by the pointers and count below.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= data;
      end
   end

   // Pointers are exactly log2(Depth) bits so they wrap on their own; the
   // extra count bit distinguishes full from empty.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// ----------------------------------------------------------------------------
// wb_arbiter
//
// Write-back arbiter in front of the register file's single write port.
// The in-order pipeline has fixed priority and cannot be back-pressured;
// mul/div results arrive over valid/ready, are buffered in wb_fifo, and
// drain whenever the pipeline is not writing. A starvation counter forces a
// one-cycle pipeline stall so a buffered result is never held off forever.
//
// Parameters:
//   WordSize  result and write-port data width
//   Depth     mul/div result FIFO entries (power of two, >= 2)
//   Starve    lost arbitrations tolerated by the FIFO head before a stall
//
// Ports:
//   clk        in   clock
//   rstn       in   asynchronous active-low reset
//   pipe_wbe   in   pipeline write request
//   pipe_rdn   in   pipeline destination register
//   pipe_rdd   in   pipeline result
//   mdu_valid  in   mul/div result offered
//   mdu_rdn    in   mul/div destination register
//   mdu_rdd    in   mul/div result
//   mdu_ready  out  FIFO can accept a mul/div result
//   stall_req  out  pipeline must not write this cycle (registered)
//   wbe        out  register-file write enable (registered)
//   rdn        out  register-file destination (registered)
//   rdd        out  register-file write data (registered)
// ----------------------------------------------------------------------------
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int WordSize = WB_WORDSIZE,
   parameter int Depth    = WB_DEPTH,
   parameter int Starve   = WB_STARVE
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                pipe_wbe,
   input  logic [4:0]          pipe_rdn,
   input  logic [WordSize-1:0] pipe_rdd,
   input  logic                mdu_valid,
   input  logic [4:0]          mdu_rdn,
   input  logic [WordSize-1:0] mdu_rdd,
   output logic                mdu_ready,
   output logic                stall_req,
   output logic                wbe,
   output logic [4:0]          rdn,
   output logic [WordSize-1:0] rdd
);

   localparam int CntW = $clog2(Starve + 1);
   localparam logic [CntW-1:0] StarveMax = CntW'(Starve);

   // Request type sized to this instance's data width.
   typedef struct packed {
      logic [4:0]          rdn;
      logic [WordSize-1:0] rdd;
   } req_t;

   req_t                fifo_data;
   req_t                fifo_head;
   logic                fifo_push;
   logic                fifo_pop;
   logic                fifo_full;
   logic                fifo_empty;

   logic                pipe_win;
   logic                wbe_next;
   logic [4:0]          rdn_next;
   logic [WordSize-1:0] rdd_next;

   logic [CntW-1:0]     starve_cnt;
   logic [CntW-1:0]     starve_next;
   logic                stall_next;

   // A result aimed at x0 still completes its handshake so the mul/div unit
   // is not held up, but it is never stored or written.
   assign mdu_ready        = !fifo_full;
   assign fifo_push        = mdu_valid && mdu_ready && wb_is_real_dest(mdu_rdn);
   assign fifo_data.rdn    = mdu_rdn;
   assign fifo_data.rdd    = mdu_rdd;

   wb_fifo #(
      .Depth   (Depth),
      .entry_t (req_t)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (fifo_push),
      .data  (fifo_data),
      .pop   (fifo_pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   // Write-port arbitration. A raised stall_req guarantees the pipeline is
   // idle, so the FIFO head goes first. Otherwise the pipeline wins whenever
   // it has a real destination; a pipeline write to x0 is simply dropped and
   // leaves the slot to the FIFO. With nothing to write, rdn/rdd hold their
   // last values and only wbe drops.
   always_comb begin
      fifo_pop = 1'b0;
      pipe_win = 1'b0;
      wbe_next = 1'b0;
      rdn_next = rdn;
      rdd_next = rdd;
      if (stall_req) begin
         if (!fifo_empty) begin
            fifo_pop = 1'b1;
            wbe_next = 1'b1;
            rdn_next = fifo_head.rdn;
            rdd_next = fifo_head.rdd;
         end
      end else if (pipe_wbe && wb_is_real_dest(pipe_rdn)) begin
         pipe_win = 1'b1;
         wbe_next = 1'b1;
         rdn_next = pipe_rdn;
         rdd_next = pipe_rdd;
      end else if (!fifo_empty) begin
         fifo_pop = 1'b1;
         wbe_next = 1'b1;
         rdn_next = fifo_head.rdn;
         rdd_next = fifo_head.rdd;
      end
   end

   // Count consecutive cycles in which a waiting FIFO head lost to the
   // pipeline. Any pop, or an empty FIFO, means nobody is waiting. The
   // stall request is raised from the next count so it lines up with the
   // cycle after the final lost arbitration, and the pop it forces clears
   // the count again, keeping the stall to exactly one cycle.
   always_comb begin
      starve_next = starve_cnt;
      if (fifo_pop || fifo_empty) begin
         starve_next = '0;
      end else if (pipe_win && (starve_cnt != StarveMax)) begin
         starve_next = starve_cnt + 1'b1;
      end
      stall_next = (starve_next == StarveMax);
   end

   // Registered write port, stall request and starvation count.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wbe        <= 1'b0;
         rdn        <= '0;
         rdd        <= '0;
         starve_cnt <= '0;
         stall_req  <= 1'b0;
      end else begin
         wbe        <= wbe_next;
         rdn        <= rdn_next;
         rdd        <= rdd_next;
         starve_cnt <= starve_next;
         stall_req  <= stall_next;
      end
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter sitting directly upstream of the general-purpose register file's single write port (wbe/rdn/rdd). Merges two result sources into that port: the in-order pipeline write-back, which has fixed priority and no back-pressure, and the multi-cycle mul/div unit, which uses valid/ready and is buffered in a small FIFO. A starvation counter raises a one-cycle pipeline stall request so buffered long-latency results always drain.

## Interface
- WordSize, 32, data width of results and of the register-file write port
- Depth, 4, mul/div result FIFO entries (power of two, ≥2)
- Starve, 8, consecutive cycles the FIFO head may lose arbitration before a stall is requested (≥1)

Ports:
- clk  in  1  clock; all state updates on posedge
- rstn  in  1  reset, asynchronous, active-low
- pipe_wbe  in  1  pipeline write request this cycle
- pipe_rdn  in  5  pipeline destination register
- pipe_rdd  in  WordSize  pipeline result
- mdu_valid  in  1  mul/div result offered
- mdu_rdn  in  5  mul/div destination register
- mdu_rdd  in  WordSize  mul/div result
- mdu_ready  out  1  FIFO can accept; transfer when mdu_valid && mdu_ready
- stall_req  out  1  upstream must hold pipe_wbe=0 in any cycle stall_req is high
- wbe  out  1  register-file write enable (registered)
- rdn  out  5  register-file destination (registered)
- rdd  out  WordSize  register-file write data (registered)

## Operation
- Reset (rstn low, any time, async): FIFO emptied, starve counter 0; wbe=0, rdn=0, rdd=0, stall_req=0, mdu_ready=1 immediately.
- mdu_ready = !full, from registered occupancy only; no push at full even if a pop occurs the same cycle.
- Accepted mdu result with mdu_rdn=0 is handshaked but not pushed (discarded).
- Arbitration each cycle, priority order:
  - stall_req high: pop FIFO head (non-empty guaranteed) to output; pipe_wbe ignored.
  - pipe_wbe && pipe_rdn≠0: pipeline result to output.
  - pipe_wbe && pipe_rdn=0: dropped; FIFO head, if any, is popped to output that cycle.
  - otherwise, FIFO non-empty: pop head to output.
  - otherwise: wbe←0, rdn/rdd hold previous values.
- Starve counter: clears on any pop or when FIFO empty; increments (saturating at Starve) when FIFO non-empty and pipeline wins.
- stall_req (registered) ← (next counter value == Starve). High for exactly one cycle; the pop in that cycle clears the counter.
- Push and pop in the same cycle are legal at any non-full occupancy; occupancy unchanged.
- FIFO pointers are log2(Depth) bits and wrap naturally; full/empty from a log2(Depth)+1-bit count.

## Timing
- Pipeline: pipe_wbe at cycle N → wbe/rdn/rdd at N+1 (latency 1).
- Mul/div: accepted at N → earliest visible at FIFO head N+1 → earliest wbe at N+2 (no bypass).
- Starvation bound: head waits at most Starve pipeline-win cycles, plus one stall cycle.
- FIFO order strictly preserved; never two writes per cycle.

## Structure
- Package wb_pkg: typedef wb_req_t {logic [4:0] rdn; logic [WordSize-1:0] rdd}; default constants WB_DEPTH=4, WB_STARVE=8.
- Sub-module wb_fifo: synchronous FIFO of wb_req_t, Depth entries, push/pop/full/empty/head, async active-low reset. Arbitration, starve counter and output registers stay in wb_arbiter.

## Test plan
- Reset mid-operation: FIFO holding 3 entries, wbe=1; drop rstn → wbe=0, rdn=0, rdd=0, mdu_ready=1, stall_req=0 same cycle; after release, no stale entries written.
- Pipe only: pipe_wbe=1, rdn=5, rdd=0xDEADBEEF at N → wbe=1, rdn=5, rdd=0xDEADBEEF at N+1; pipe_rdn=0 → wbe=0.
- FIFO drain/order: push (1,0x11),(2,0x22),(3,0x33),(4,0x44), no pipe → mdu_ready=0 after 4th; outputs 1,2,3,4 in order on consecutive cycles starting 2 cycles after the first push.
- Full with same-cycle pop: FIFO full, pop occurring, mdu_valid=1 → no transfer that cycle; accepted the next cycle.
- Starvation: one entry (7,0x77) buffered, pipe_wbe=1 continuously with Starve=8 → stall_req high after 8 pipe wins, wbe=1/rdn=7/rdd=0x77 in the stall cycle, stall_req low next cycle.
- mdu_rdn=0: handshake completes, occupancy unchanged, no write ever issued.
